// File: rtl/dual_port_pkg.sv
// Shared defaults and request/response bundles for the single-clock dual-port RAM.
package dual_port_pkg;

  localparam int WIDTH_DEF      = 12;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int CNT_WIDTH_DEF  = 8;

  typedef struct packed {
    logic                      en;
    logic                      we;
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [WIDTH_DEF-1:0]      din;
  } port_req_t;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] dout;
    logic                 valid;
  } port_rsp_t;

endpackage

// File: rtl/dpram_rd_stage.sv
// Per-port read output register and valid strobe.
// DPRAM_OUT_REG_EN adds a second resettable output stage (read latency 2).
module dpram_rd_stage
  import dual_port_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rd,
  input  logic [WIDTH_DEF-1:0] i_data,
  output port_rsp_t            o_rsp
);

  port_rsp_t s1;

  // dout holds across writes and idle cycles; only valid pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1 <= '0;
    end else begin
      s1.valid <= i_rd;
      if (i_rd) s1.dout <= i_data;
    end
  end

`ifdef DPRAM_OUT_REG_EN
  port_rsp_t s2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) s2 <= '0;
    else          s2 <= s1;
  end

  assign o_rsp = s2;
`else
  assign o_rsp = s1;
`endif

endmodule

// File: rtl/dual_port_ram_sc.sv
// Single-clock true dual-port RAM, read-first, port A wins write/write conflicts.
// DPRAM_OUT_REG_EN delays read data, valid, collision and count by one stage.
module dual_port_ram_sc
  import dual_port_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = 2**ADDR_WIDTH,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en_a,
  input  logic                  i_we_a,
  input  logic [ADDR_WIDTH-1:0] i_addr_a,
  input  logic [WIDTH-1:0]      i_din_a,
  output logic [WIDTH-1:0]      o_dout_a,
  output logic                  o_valid_a,
  input  logic                  i_en_b,
  input  logic                  i_we_b,
  input  logic [ADDR_WIDTH-1:0] i_addr_b,
  input  logic [WIDTH-1:0]      i_din_b,
  output logic [WIDTH-1:0]      o_dout_b,
  output logic                  o_valid_b,
  output logic                  o_collision,
  output logic [CNT_WIDTH-1:0]  o_coll_cnt
);

  logic [WIDTH-1:0] mem [DEPTH];

  port_req_t req_a, req_b;
  port_rsp_t rsp_a, rsp_b;
  logic      wr_a, wr_b, same_addr, coll;

  assign req_a = '{en: i_en_a, we: i_we_a, addr: i_addr_a, din: i_din_a};
  assign req_b = '{en: i_en_b, we: i_we_b, addr: i_addr_b, din: i_din_b};

  assign same_addr = req_a.en & req_b.en & (req_a.addr == req_b.addr);
  assign coll      = same_addr & (req_a.we | req_b.we);
  assign wr_a      = req_a.en & req_a.we;
  // B's write is dropped when A writes the same word
  assign wr_b      = req_b.en & req_b.we & ~(wr_a & same_addr);

  // Memory contents survive reset; only writes are blocked while it is held
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (wr_a) mem[req_a.addr] <= req_a.din;
      if (wr_b) mem[req_b.addr] <= req_b.din;
    end
  end

  dpram_rd_stage u_rd_a (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_rd    (req_a.en & ~req_a.we),
    .i_data  (mem[req_a.addr]),
    .o_rsp   (rsp_a)
  );

  dpram_rd_stage u_rd_b (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_rd    (req_b.en & ~req_b.we),
    .i_data  (mem[req_b.addr]),
    .o_rsp   (rsp_b)
  );

  assign o_dout_a  = rsp_a.dout;
  assign o_valid_a = rsp_a.valid;
  assign o_dout_b  = rsp_b.dout;
  assign o_valid_b = rsp_b.valid;

  logic                 coll_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      coll_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      coll_q <= coll;
      if (coll && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef DPRAM_OUT_REG_EN
  logic                 coll_q2;
  logic [CNT_WIDTH-1:0] cnt_q2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      coll_q2 <= 1'b0;
      cnt_q2  <= '0;
    end else begin
      coll_q2 <= coll_q;
      cnt_q2  <= cnt_q;
    end
  end

  assign o_collision = coll_q2;
  assign o_coll_cnt  = cnt_q2;
`else
  assign o_collision = coll_q;
  assign o_coll_cnt  = cnt_q;
`endif

endmodule

// File: tb/tb_dual_port_ram_sc.sv
// Self-checking bench for dual_port_ram_sc: array reference model plus directed literal checks.
module tb_dual_port_ram_sc;

  localparam int W     = 12;
  localparam int AW    = 10;
  localparam int CW    = 8;
  localparam int DEPTH = 1024;
  localparam int CMAX  = 255;
`ifdef DPRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk, rst_n;
  logic          en_a, we_a, en_b, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [W-1:0]  din_a, din_b;
  logic [W-1:0]  dout_a, dout_b;
  logic          valid_a, valid_b, coll;
  logic [CW-1:0] coll_cnt;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_on  = 0;

  dual_port_ram_sc dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en_a      (en_a),
    .i_we_a      (we_a),
    .i_addr_a    (addr_a),
    .i_din_a     (din_a),
    .o_dout_a    (dout_a),
    .o_valid_a   (valid_a),
    .i_en_b      (en_b),
    .i_we_b      (we_b),
    .i_addr_b    (addr_b),
    .i_din_b     (din_b),
    .o_dout_b    (dout_b),
    .o_valid_b   (valid_b),
    .o_collision (coll),
    .o_coll_cnt  (coll_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: word array plus the values each output must show after
  // the edge that accepted a request (s1) and one edge later (s2).
  int mem_m [DEPTH];
  int s1_da, s1_db, s1_va, s1_vb, s1_c, s1_n;
  int s2_da, s2_db, s2_va, s2_vb, s2_c, s2_n;

  always @(posedge clk or negedge rst_n) begin
    bit is_coll;
    if (!rst_n) begin
      s1_da = 0; s1_db = 0; s1_va = 0; s1_vb = 0; s1_c = 0; s1_n = 0;
      s2_da = 0; s2_db = 0; s2_va = 0; s2_vb = 0; s2_c = 0; s2_n = 0;
    end else begin
      s2_da = s1_da; s2_db = s1_db; s2_va = s1_va; s2_vb = s1_vb;
      s2_c = s1_c; s2_n = s1_n;
      is_coll = en_a && en_b && (addr_a == addr_b) && (we_a || we_b);
      s1_va = (en_a && !we_a) ? 1 : 0;
      s1_vb = (en_b && !we_b) ? 1 : 0;
      if (s1_va == 1) s1_da = mem_m[addr_a];
      if (s1_vb == 1) s1_db = mem_m[addr_b];
      s1_c = is_coll ? 1 : 0;
      if (is_coll && s1_n < CMAX) s1_n = s1_n + 1;
      if (en_b && we_b) mem_m[addr_b] = int'(din_b);
      if (en_a && we_a) mem_m[addr_a] = int'(din_a);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("dout_a",    32'(dout_a),   32'(LAT == 2 ? s2_da : s1_da));
      check("valid_a",   32'(valid_a),  32'(LAT == 2 ? s2_va : s1_va));
      check("dout_b",    32'(dout_b),   32'(LAT == 2 ? s2_db : s1_db));
      check("valid_b",   32'(valid_b),  32'(LAT == 2 ? s2_vb : s1_vb));
      check("collision", 32'(coll),     32'(LAT == 2 ? s2_c  : s1_c));
      check("coll_cnt",  32'(coll_cnt), 32'(LAT == 2 ? s2_n  : s1_n));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_a = 0; we_a = 0; en_b = 0; we_b = 0;
  endtask

  task automatic set_a(input bit en, input bit we, input int addr, input int din);
    en_a = en; we_a = we; addr_a = AW'(addr); din_a = W'(din);
  endtask

  task automatic set_b(input bit en, input bit we, input int addr, input int din);
    en_b = en; we_b = we; addr_b = AW'(addr); din_b = W'(din);
  endtask

  // Retire the edge carrying the request, then wait out the remaining latency
  task automatic finish_req();
    tick();
    idle();
    repeat (LAT - 1) tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dout_a"},   32'(dout_a),   0);
    check({tag, "_valid_a"},  32'(valid_a),  0);
    check({tag, "_dout_b"},   32'(dout_b),   0);
    check({tag, "_valid_b"},  32'(valid_b),  0);
    check({tag, "_coll"},     32'(coll),     0);
    check({tag, "_coll_cnt"}, 32'(coll_cnt), 0);
  endtask

  initial begin
    rst_n = 0;
    idle();
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);

    // Reset state and first idle cycle
    repeat (3) tick();
    check_zero("rst");
    @(negedge clk);
    rst_n  = 1;
    chk_on = 1;
    tick();
    check("idle_valid_a", 32'(valid_a), 0);
    check("idle_valid_b", 32'(valid_b), 0);

    // Write on A, read back on B
    set_a(1, 1, 'h005, 'hABC);
    tick();
    idle();
    set_b(1, 0, 'h005, 0);
    finish_req();
    check("wr_rd_dout_b",  32'(dout_b),  'hABC);
    check("wr_rd_valid_b", 32'(valid_b), 1);

    // Write/write collision: A wins
    set_a(1, 1, 'h010, 'h111);
    set_b(1, 1, 'h010, 'h222);
    finish_req();
    check("ww_coll", 32'(coll),     1);
    check("ww_cnt",  32'(coll_cnt), 1);
    set_a(1, 0, 'h010, 0);
    finish_req();
    check("ww_winner", 32'(dout_a), 'h111);

    // Write/read collision: reader sees old data, write lands
    set_a(1, 1, 'h020, 'h0F0);
    tick();
    set_a(1, 1, 'h020, 'h333);
    set_b(1, 0, 'h020, 0);
    finish_req();
    check("wr_old_data", 32'(dout_b),   'h0F0);
    check("wr_cnt",      32'(coll_cnt), 2);
    set_b(1, 0, 'h020, 0);
    finish_req();
    check("wr_new_data", 32'(dout_b), 'h333);

    // Address extremes, then counter saturation
    set_a(1, 1, 'h000, 'h5A5);
    set_b(1, 1, 'h3FF, 'hA5A);
    tick();
    set_a(1, 0, 'h3FF, 0);
    set_b(1, 0, 'h000, 0);
    finish_req();
    check("top_addr",  32'(dout_a), 'hA5A);
    check("zero_addr", 32'(dout_b), 'h5A5);
    for (int i = 0; i < 260; i++) begin
      set_a(1, 1, (i % 2 == 0) ? 'h010 : 'h020, int'($urandom_range(0, 4095)));
      set_b(1, ($urandom_range(0, 1) == 1), (i % 2 == 0) ? 'h010 : 'h020,
            int'($urandom_range(0, 4095)));
      tick();
    end
    idle();
    repeat (LAT) tick();
    check("cnt_saturated", 32'(coll_cnt), CMAX);

    // Fill every word so random reads always hit known data
    for (int i = 0; i < DEPTH / 2; i++) begin
      set_a(1, 1, i, int'($urandom_range(0, 4095)));
      set_b(1, 1, i + DEPTH / 2, int'($urandom_range(0, 4095)));
      tick();
    end

    // Random traffic, often crowded onto a few addresses
    for (int i = 0; i < 3000; i++) begin
      bit crowd;
      crowd = ($urandom_range(0, 1) == 1);
      set_a(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
            crowd ? int'($urandom_range(0, 3)) : int'($urandom_range(0, DEPTH - 1)),
            int'($urandom_range(0, 4095)));
      set_b(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
            crowd ? int'($urandom_range(0, 3)) : int'($urandom_range(0, DEPTH - 1)),
            int'($urandom_range(0, 4095)));
      tick();
    end

    // Reset in the middle of a read stream
    set_a(1, 1, 'h155, 'h9C3);
    set_b(0, 0, 0, 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      set_a(1, 0, int'($urandom_range(0, DEPTH - 1)), 0);
      set_b(1, 0, int'($urandom_range(0, DEPTH - 1)), 0);
      tick();
    end
    #2;
    rst_n = 0;
    #1;
    check_zero("midrst");
    idle();
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1;
    tick();
    check("post_rst_valid_a", 32'(valid_a), 0);
    check("post_rst_valid_b", 32'(valid_b), 0);
    set_a(1, 0, 'h155, 0);
    set_b(1, 0, int'($urandom_range(0, DEPTH - 1)), 0);
    finish_req();
    check("post_rst_data", 32'(dout_a), 'h9C3);
    for (int i = 0; i < 20; i++) begin
      set_a(1, 0, int'($urandom_range(0, DEPTH - 1)), 0);
      set_b(1, 0, int'($urandom_range(0, DEPTH - 1)), 0);
      tick();
    end
    idle();
    repeat (3) tick();

    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
